vadd_minmax_stream: RTL and testbench

//  Next-generation SIMD integer add/sub/min/max/compare lane for the vALU. It adds a ready/valid handshake with

---
 rtl/vadd_minmax_stream.sv | 226 ++++++++++++++++++++++
 tb/tb_vadd_minmax_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vadd_minmax_stream.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module : vadd_minmax_stream
// Brief  : SIMD add/sub/min/max/compare lane behind a ready/valid pipeline.
//          Optional saturating ops are built when VADD_SAT_EN is defined.
// Rev    : 1.0
// ============================================================================
module vadd_minmax_stream #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int BE_WIDTH      = DATA_WIDTH / 8,
  parameter int PIPE_STAGES   = 3,
  parameter bit ENABLE_64_BIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_vec0,
  input  logic [DATA_WIDTH-1:0] in_vec1,
  input  logic [1:0]            in_sew,
  input  logic [3:0]            in_op,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [BE_WIDTH-1:0]   in_be,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_vec,
  output logic [BE_WIDTH-1:0]   out_mask,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [BE_WIDTH-1:0]   out_be,
  output logic                  out_sat
);

  localparam int         LAST        = PIPE_STAGES - 1;
  localparam logic [3:0] C_OP_ADD    = 4'd0;
  localparam logic [3:0] C_OP_SUB    = 4'd1;
  localparam logic [3:0] C_OP_MINU   = 4'd2;
  localparam logic [3:0] C_OP_MIN    = 4'd3;
  localparam logic [3:0] C_OP_MAXU   = 4'd4;
  localparam logic [3:0] C_OP_MAX    = 4'd5;
  localparam logic [3:0] C_OP_MSEQ   = 4'd6;
  localparam logic [3:0] C_OP_MSNE   = 4'd7;
  localparam logic [3:0] C_OP_MSLTU  = 4'd8;
  localparam logic [3:0] C_OP_MSLT   = 4'd9;
  localparam logic [3:0] C_OP_SADDU  = 4'd10;
  localparam logic [3:0] C_OP_SADD   = 4'd11;
  localparam logic [3:0] C_OP_SSUBU  = 4'd12;
  localparam logic [3:0] C_OP_SSUB   = 4'd13;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] vec;
    logic [BE_WIDTH-1:0]   mask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BE_WIDTH-1:0]   be;
`ifdef VADD_SAT_EN
    logic                  sat;
`endif
  } pay_t;

  logic [DATA_WIDTH-1:0] w_res_s  [4];
  logic [BE_WIDTH-1:0]   w_mask_s [4];
`ifdef VADD_SAT_EN
  logic [3:0]            w_sat_s;
`endif

  // One full-width datapath per element size; in_sew picks the result below.
  for (genvar s = 0; s < 4; s++) begin : g_sew
    localparam int W = 8 << s;
    localparam int N = DATA_WIDTH / W;
    logic [DATA_WIDTH-1:0] res;
    logic [BE_WIDTH-1:0]   mask;
`ifdef VADD_SAT_EN
    logic [BE_WIDTH-1:0]   satv;
`endif

    if ((W <= DATA_WIDTH) && ((s < 3) || ENABLE_64_BIT)) begin : g_lanes
      for (genvar e = 0; e < N; e++) begin : g_elem
        localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
        localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
        logic [W-1:0] a, b, r;
        logic         m, ltu, lts;
`ifdef VADD_SAT_EN
        logic         sat, c;
`endif
        assign a   = in_vec0[e*W +: W];
        assign b   = in_vec1[e*W +: W];
        assign ltu = (a < b);
        assign lts = ($signed(a) < $signed(b));

        always_comb begin
          r = '0;
          m = 1'b0;
`ifdef VADD_SAT_EN
          sat = 1'b0;
          c   = 1'b0;
`endif
          case (in_op)
            C_OP_ADD:   r = a + b;
            C_OP_SUB:   r = a - b;
            C_OP_MINU:  r = ltu ? a : b;
            C_OP_MIN:   r = lts ? a : b;
            C_OP_MAXU:  r = ltu ? b : a;
            C_OP_MAX:   r = lts ? b : a;
            C_OP_MSEQ:  m = (a == b);
            C_OP_MSNE:  m = (a != b);
            C_OP_MSLTU: m = ltu;
            C_OP_MSLT:  m = lts;
`ifdef VADD_SAT_EN
            C_OP_SADDU: begin
              {c, r} = {1'b0, a} + {1'b0, b};
              if (c) begin r = '1; sat = 1'b1; end
            end
            C_OP_SADD: begin
              r = a + b;
              if ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1])) begin
                r   = a[W-1] ? SMIN : SMAX;
                sat = 1'b1;
              end
            end
            C_OP_SSUBU: begin
              r = a - b;
              if (ltu) begin r = '0; sat = 1'b1; end
            end
            C_OP_SSUB: begin
              r = a - b;
              if ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1])) begin
                r   = a[W-1] ? SMIN : SMAX;
                sat = 1'b1;
              end
            end
`else
            C_OP_SADDU, C_OP_SADD: r = a + b;
            C_OP_SSUBU, C_OP_SSUB: r = a - b;
`endif
            default: ;
          endcase
        end

        assign res[e*W +: W] = r;
        assign mask[e]       = m;
`ifdef VADD_SAT_EN
        assign satv[e]       = sat;
`endif
      end

      if (N < BE_WIDTH) begin : g_pad
        assign mask[BE_WIDTH-1:N] = '0;
`ifdef VADD_SAT_EN
        assign satv[BE_WIDTH-1:N] = '0;
`endif
      end
    end else begin : g_off
      assign res  = '0;
      assign mask = '0;
`ifdef VADD_SAT_EN
      assign satv = '0;
`endif
    end

    assign w_res_s[s]  = res;
    assign w_mask_s[s] = mask;
`ifdef VADD_SAT_EN
    assign w_sat_s[s]  = |satv;
`endif
  end

  pay_t w_pay;
  assign w_pay.vec  = w_res_s[in_sew];
  assign w_pay.mask = w_mask_s[in_sew];
  assign w_pay.addr = in_addr;
  assign w_pay.be   = in_be;
`ifdef VADD_SAT_EN
  assign w_pay.sat  = w_sat_s[in_sew];
`endif

  logic [PIPE_STAGES-1:0] vld_q, vld_d, w_ld;
  pay_t                   pay_q [PIPE_STAGES];
  pay_t                   pay_d [PIPE_STAGES];

  // A stage can load when any stage from it to the output has a hole, or the output drains.
  always_comb begin
    for (int i = 0; i < PIPE_STAGES; i++) begin
      w_ld[i] = out_ready;
      for (int j = i; j < PIPE_STAGES; j++) begin
        if (!vld_q[j]) w_ld[i] = 1'b1;
      end
    end
    vld_d = vld_q;
    pay_d = pay_q;
    if (w_ld[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) pay_d[0] = w_pay;
    end
    for (int i = 1; i < PIPE_STAGES; i++) begin
      if (w_ld[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) pay_d[i] = pay_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) pay_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      pay_q <= pay_d;
    end
  end

  assign in_ready  = w_ld[0];
  assign out_valid = vld_q[LAST];
  assign out_vec   = pay_q[LAST].vec;
  assign out_mask  = pay_q[LAST].mask;
  assign out_addr  = pay_q[LAST].addr;
  assign out_be    = pay_q[LAST].be;
`ifdef VADD_SAT_EN
  assign out_sat   = pay_q[LAST].sat;
`else
  assign out_sat   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vadd_minmax_stream.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module : tb_vadd_minmax_stream
// Brief  : Directed self-checking bench for vadd_minmax_stream (defaults).
// Rev    : 1.0
// ============================================================================
module tb_vadd_minmax_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_vec0 = '0;
  logic [63:0] in_vec1 = '0;
  logic [1:0]  in_sew = '0;
  logic [3:0]  in_op = '0;
  logic [31:0] in_addr = '0;
  logic [7:0]  in_be = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_vec;
  logic [7:0]  out_mask;
  logic [31:0] out_addr;
  logic [7:0]  out_be;
  logic        out_sat;

  int checks = 0;
  int errors = 0;

  logic [63:0] r_vec;
  logic [7:0]  r_mask, r_be;
  logic [31:0] r_addr;
  logic        r_sat;

  always #5 clk = ~clk;

  vadd_minmax_stream dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vec0(in_vec0), .in_vec1(in_vec1), .in_sew(in_sew), .in_op(in_op),
    .in_addr(in_addr), .in_be(in_be),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_mask(out_mask), .out_addr(out_addr),
    .out_be(out_be), .out_sat(out_sat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one beat with out_ready high, checks the latency, captures the result.
  task automatic send_one(input logic [1:0] sew, input logic [3:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [31:0] addr, input logic [7:0] be);
    int k;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sew = sew; in_op = op; in_vec0 = a; in_vec1 = b; in_addr = addr; in_be = be;
    #1;
    check("accept_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, 3);
    r_vec = out_vec; r_mask = out_mask; r_addr = out_addr; r_be = out_be; r_sat = out_sat;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  tx, rx, occ, cyc;
    bit  saw_full, acc, dlv, seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_vec", out_vec, 64'h0);
    check("rst_out_mask", out_mask, 8'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_out_be", out_be, 8'h0);
    check("rst_out_sat", out_sat, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // SEW=8 ADD: byte0 wraps without carrying into byte1
    send_one(2'd0, 4'd0, 64'h10203040_506070FF, 64'h01010101_01010101, 32'hDEAD0001, 8'hA5);
    check("add8_vec", r_vec, 64'h11213141_51617100);
    check("add8_mask", r_mask, 8'h00);
    check("add8_addr", r_addr, 32'hDEAD0001);
    check("add8_be", r_be, 8'hA5);

    // SEW=16 MIN / MINU
    send_one(2'd1, 4'd3, 64'h0001_0005_FFFF_8000, 64'h0002_0003_0001_7FFF, 32'h1, 8'hFF);
    check("min16_vec", r_vec, 64'h0001_0003_FFFF_8000);
    send_one(2'd1, 4'd2, 64'h0001_0005_FFFF_8000, 64'h0002_0003_0001_7FFF, 32'h2, 8'hFF);
    check("minu16_vec", r_vec, 64'h0001_0003_0001_7FFF);

    // SEW=32 compares
    send_one(2'd2, 4'd9, 64'h00000005_FFFFFFFF, 64'h00000005_00000000, 32'h3, 8'hFF);
    check("mslt32_mask", r_mask, 8'h01);
    check("mslt32_vec", r_vec, 64'h0);
    send_one(2'd2, 4'd8, 64'h00000005_FFFFFFFF, 64'h00000005_00000000, 32'h4, 8'hFF);
    check("msltu32_mask", r_mask, 8'h00);
    send_one(2'd2, 4'd6, 64'h00000005_FFFFFFFF, 64'h00000005_00000000, 32'h5, 8'hFF);
    check("mseq32_mask", r_mask, 8'h02);
    send_one(2'd2, 4'd7, 64'h00000005_FFFFFFFF, 64'h00000005_00000000, 32'h6, 8'hFF);
    check("msne32_mask", r_mask, 8'h01);

    // SEW=8 MSEQ uses every mask bit
    send_one(2'd0, 4'd6, 64'h00112233_44556677, 64'hFF112233_44556677, 32'h7, 8'hFF);
    check("mseq8_mask", r_mask, 8'h7F);

    // SEW=32 SUB borrows stay inside each element
    send_one(2'd2, 4'd1, 64'h00000000_00000005, 64'h00000001_00000007, 32'h8, 8'hFF);
    check("sub32_vec", r_vec, 64'hFFFFFFFF_FFFFFFFE);

    // SEW=8 MAX / MAXU
    send_one(2'd0, 4'd5, 64'h807F, 64'h7F80, 32'h9, 8'hFF);
    check("max8_vec", r_vec, 64'h7F7F);
    send_one(2'd0, 4'd4, 64'h807F, 64'h7F80, 32'hA, 8'hFF);
    check("maxu8_vec", r_vec, 64'h8080);

    // SEW=64 with 64-bit support disabled, and a reserved opcode
    send_one(2'd3, 4'd0, 64'h1, 64'h2, 32'hB, 8'hFF);
    check("sew64_vec", r_vec, 64'h0);
    check("sew64_mask", r_mask, 8'h00);
    send_one(2'd0, 4'd14, 64'h01010101_01010101, 64'h01010101_01010101, 32'hC, 8'h3C);
    check("rsvd_vec", r_vec, 64'h0);
    check("rsvd_mask", r_mask, 8'h00);
    check("rsvd_be", r_be, 8'h3C);

    // Saturating ops
    send_one(2'd0, 4'd11, 64'h7F, 64'h01, 32'hD, 8'hFF);
`ifdef VADD_SAT_EN
    check("sadd8_vec", r_vec, 64'h7F);
    check("sadd8_sat", r_sat, 1'b1);
`else
    check("sadd8_vec", r_vec, 64'h80);
    check("sadd8_sat", r_sat, 1'b0);
`endif
    send_one(2'd0, 4'd10, 64'hFF, 64'h01, 32'hE, 8'hFF);
`ifdef VADD_SAT_EN
    check("saddu8_vec", r_vec, 64'hFF);
    check("saddu8_sat", r_sat, 1'b1);
`else
    check("saddu8_vec", r_vec, 64'h00);
    check("saddu8_sat", r_sat, 1'b0);
`endif
    send_one(2'd0, 4'd12, 64'h00, 64'h01, 32'hF, 8'hFF);
`ifdef VADD_SAT_EN
    check("ssubu8_vec", r_vec, 64'h00);
`else
    check("ssubu8_vec", r_vec, 64'hFF);
`endif

    // Stream of 10 beats with a backpressure window
    tx = 0; rx = 0; occ = 0; cyc = 0; saw_full = 1'b0;
    while (rx < 10 && cyc < 80) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 9);
      in_valid  = (tx < 10);
      in_sew = 2'd0; in_op = 4'd0;
      in_vec0 = 64'(tx); in_vec1 = 64'h1;
      in_addr = 32'h100 + 32'(tx); in_be = 8'(tx);
      #1;
      check("stream_in_ready", in_ready, (occ < 3) || out_ready);
      if (!in_ready) saw_full = 1'b1;
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (out_valid) begin
        check("stream_addr", out_addr, 32'h100 + 32'(rx));
        check("stream_vec", out_vec, 64'(rx + 1));
      end
      if (dlv) rx++;
      if (acc) tx++;
      occ = occ + int'(acc) - int'(dlv);
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_count", rx, 10);
    check("stream_backpressure", saw_full, 1'b1);

    // Reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    in_sew = 2'd0; in_op = 4'd0; in_vec0 = 64'h5; in_vec1 = 64'h5; in_addr = 32'h200; in_be = 8'h11;
    @(negedge clk);
    in_addr = 32'h201;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_vec", out_vec, 64'h0);
    check("midrst_out_addr", out_addr, 32'h0);
    check("midrst_out_be", out_be, 8'h0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_discard", seen, 1'b0);
    send_one(2'd1, 4'd0, 64'h0000_0000_1234_FFFF, 64'h0000_0000_0001_0001, 32'h300, 8'h0F);
    check("postrst_vec", r_vec, 64'h0000_0000_1235_0000);
    check("postrst_addr", r_addr, 32'h300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
